rat_uart_tx: RTL and testbench
==============================

# rat_uart_tx

Memory-mapped UART transmitter peripheral on the RAT MCU output bus. It decodes MCU port writes (PORT_ID/OUT_PORT/IO_STRB), buffers bytes in a small FIFO, and serializes them as 8N1 frames on a TX pin. A status byte goes to the wrapper's IN_PORT mux, and a one-cycle completion pulse is available for the MCU interrupt input. It runs in the MCU clock domain (50 MHz divided clock).

## Interface

Parameters:
- CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200); legal range ≥ 2
- FIFO_DEPTH, 8, transmit FIFO entries; power of two
- DATA_PORT_ID, 8'h82, output port ID whose writes push a byte
- STATUS_PORT_ID, 8'h83, port ID for status reads; writes to it clear overrun

Ports:
- CLK  in  1  MCU clock; all state on rising edge
- RST_N  in  1  asynchronous, active-low reset
- PORT_ID  in  8  MCU port address
- OUT_PORT  in  8  MCU write data
- IO_STRB  in  1  MCU write strobe, one cycle per OUT instruction
- TX  out  1  serial output, idle high
- STATUS  out  8  combinational: [7:4] FIFO count, [3] overrun, [2] busy, [1] full, [0] empty
- TX_DONE  out  1  one-cycle pulse when the last queued frame finishes

## Operation

- Reset (RST_N low, asynchronous):
  - TX=1, TX_DONE=0
  - FIFO count=0; read and write pointers=0
  - overrun=0, FSM=IDLE, baud counter=0
  - STATUS=8'h01
- Write decode: a push occurs when IO_STRB=1 and PORT_ID==DATA_PORT_ID at a rising edge.
  - If not full, OUT_PORT is pushed.
  - If full, the byte is dropped and overrun is set (sticky).
- Overrun clear: IO_STRB=1 and PORT_ID==STATUS_PORT_ID clears overrun. The data value is ignored.
- A push on a full FIFO in the same cycle as a pop is accepted; count is unchanged and overrun is not set.
- Pop on an empty FIFO never occurs. Push on an empty FIFO is always accepted.
- FSM:
  - IDLE: if FIFO not empty, pop the head into the shift register, clear the baud counter, go to START. Otherwise stay.
  - START: TX=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: TX=shift[0] for CLKS_PER_BIT cycles per bit. Shift right after each bit. After bit 7, go to STOP.
  - STOP: TX=1 for CLKS_PER_BIT cycles, then go to IDLE. TX_DONE=1 for that one cycle if the FIFO is empty at that edge.
- busy = (state != IDLE).
- Baud counter width: clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1 with no overshoot.
- Count width: clog2(FIFO_DEPTH)+1. STATUS[7:4] is count zero-extended or truncated to 4 bits.
- Pointers wrap modulo FIFO_DEPTH.
- Byte order: FIFO order. Bit order: LSB first.

## Timing

- A push sampled at edge N updates count at N. The FSM pops at edge N+1 when idle, and TX falls after edge N+1.
- Every state transition and TX change is registered; TX is driven from a flop (no glitches).
- Frame length is exactly 10*CLKS_PER_BIT cycles.
- Back-to-back frames have exactly one IDLE cycle between stop-bit end and the next start bit, so frame period = 10*CLKS_PER_BIT+1.
- TX_DONE asserts in the cycle after the final stop-bit cycle and lasts one cycle. It never asserts if a new frame starts from queued data.
- STATUS reflects registered state with zero combinational dependency on PORT_ID or IO_STRB.
- Reset mid-frame: TX goes to 1 asynchronously, all queued bytes are discarded, and the partial frame is not resumed.

## Test plan

All tests use CLKS_PER_BIT=4, FIFO_DEPTH=8.
- Reset: hold RST_N=0 mid-activity → TX=1, TX_DONE=0, STATUS=8'h01. After release, TX stays 1 with no strobes.
- Single byte: write 8'hA5 to 8'h82 at edge N → TX low after N+1 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then stop high for 4 cycles. TX_DONE is pulsed once, and STATUS returns to 8'h01.
- Fill and overflow: 9 consecutive writes (bytes 1..9).
  - After the 9th write, STATUS=8'h86.
  - A 10th write (8'hEE) is dropped and STATUS=8'h8E.
  - Bytes 1..9 are transmitted in order with 41-cycle frame spacing; 8'hEE never appears.
  - TX_DONE is pulsed only after byte 9.
- Overrun clear: from overrun=1, write any value to 8'h83 → STATUS[3]=0 on the next cycle. The FIFO and transmission are unaffected.
- Decode rejection:
  - IO_STRB=1 with PORT_ID=8'h40 → no push, TX idle.
  - PORT_ID=8'h82 with IO_STRB=0 → no push.
- Full plus simultaneous pop: FIFO full while the FSM is IDLE-popping, with a write in the same cycle → write accepted, count stays 8, overrun stays 0.

Source files
------------

// File: rtl/rat_uart_tx.sv
// rat_uart_fifo: generic single-clock FIFO with occupancy count, head visible combinationally.
// Latency: a push is visible at the head one cycle after the push edge.
// Backpressure: push_rdy drops when full unless a pop happens in the same cycle.
module rat_uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    output logic             push_rdy,
    input  logic             pop_vld,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_acc;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign push_rdy = !full || pop_vld;
    assign push_acc = push_vld && push_rdy;
    assign pop_dat  = mem[rd_ptr];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_acc) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_vld)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push_acc) - CNT_W'(pop_vld);
        end
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge CLK) begin
        if (push_acc) mem[wr_ptr] <= push_dat;
    end
endmodule

// rat_uart_tx: RAT MCU port-mapped 8N1 UART transmitter with byte FIFO, status byte and done pulse.
// Latency: push at edge N, start bit driven after edge N+1; frame 10*CLKS_PER_BIT cycles, one idle cycle between frames.
// Backpressure: none on the MCU bus; writes to a full FIFO are dropped and raise sticky overrun.
module rat_uart_tx #(
    parameter int          CLKS_PER_BIT   = 434,
    parameter int          FIFO_DEPTH     = 8,
    parameter logic [7:0]  DATA_PORT_ID   = 8'h82,
    parameter logic [7:0]  STATUS_PORT_ID = 8'h83
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [7:0] PORT_ID,
    input  logic [7:0] OUT_PORT,
    input  logic       IO_STRB,
    output logic       TX,
    output logic [7:0] STATUS,
    output logic       TX_DONE
);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    typedef struct packed {
        logic [3:0] cnt;
        logic       overrun;
        logic       busy;
        logic       full;
        logic       empty;
    } status_t;

    state_t            state, state_nxt;
    logic [BAUD_W-1:0] baud_cnt, baud_nxt;
    logic [2:0]        bit_idx, bit_nxt;
    logic [7:0]        shift, shift_nxt;
    logic              tx_q, tx_nxt;
    logic              done_q, done_nxt;
    logic              overrun;
    logic              baud_last;

    logic              data_wr;
    logic              stat_wr;
    logic              fifo_pop;
    logic              push_rdy;
    logic [7:0]        fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [3:0]        cnt4;
    status_t           status;

    assign data_wr = IO_STRB && (PORT_ID == DATA_PORT_ID);
    assign stat_wr = IO_STRB && (PORT_ID == STATUS_PORT_ID);

    rat_uart_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .push_vld (data_wr),
        .push_dat (OUT_PORT),
        .push_rdy (push_rdy),
        .pop_vld  (fifo_pop),
        .pop_dat  (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            overrun <= 1'b0;
        end else if (data_wr && !push_rdy) begin
            overrun <= 1'b1;
        end else if (stat_wr) begin
            overrun <= 1'b0;
        end
    end

    assign baud_last = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));

    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt;
        bit_nxt   = bit_idx;
        shift_nxt = shift;
        tx_nxt    = tx_q;
        done_nxt  = 1'b0;
        fifo_pop  = 1'b0;
        case (state)
            IDLE: begin
                tx_nxt = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    shift_nxt = fifo_head;
                    baud_nxt  = '0;
                    state_nxt = START;
                    tx_nxt    = 1'b0;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_nxt  = '0;
                    bit_nxt   = 3'd0;
                    state_nxt = DATA;
                    tx_nxt    = shift[0];
                end else begin
                    baud_nxt = baud_cnt + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_nxt  = '0;
                    shift_nxt = {1'b0, shift[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_nxt = STOP;
                        tx_nxt    = 1'b1;
                    end else begin
                        bit_nxt = bit_idx + 3'd1;
                        tx_nxt  = shift[1];
                    end
                end else begin
                    baud_nxt = baud_cnt + BAUD_W'(1);
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_nxt  = '0;
                    state_nxt = IDLE;
                    // Suppress the pulse when queued data will start another frame.
                    done_nxt  = fifo_empty;
                end else begin
                    baud_nxt = baud_cnt + BAUD_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                tx_nxt    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx_q     <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_nxt;
            bit_idx  <= bit_nxt;
            shift    <= shift_nxt;
            tx_q     <= tx_nxt;
            done_q   <= done_nxt;
        end
    end

    generate
        if (CNT_W >= 4) begin : g_cnt_trunc
            assign cnt4 = fifo_count[3:0];
        end else begin : g_cnt_ext
            assign cnt4 = {{(4 - CNT_W){1'b0}}, fifo_count};
        end
    endgenerate

    always_comb begin
        status         = '0;
        status.cnt     = cnt4;
        status.overrun = overrun;
        status.busy    = (state != IDLE);
        status.full    = fifo_full;
        status.empty   = fifo_empty;
    end

    assign STATUS  = status;
    assign TX      = tx_q;
    assign TX_DONE = done_q;
endmodule

// File: tb/tb_rat_uart_tx.sv
// Directed bench for rat_uart_tx with a frame-position reference model and a serial receiver.
module tb_rat_uart_tx;
    localparam int C = 4;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [7:0] PORT_ID = 8'h00;
    logic [7:0] OUT_PORT = 8'h00;
    logic       IO_STRB = 1'b0;
    logic       TX;
    logic [7:0] STATUS;
    logic       TX_DONE;

    rat_uart_tx #(
        .CLKS_PER_BIT   (C),
        .FIFO_DEPTH     (8),
        .DATA_PORT_ID   (8'h82),
        .STATUS_PORT_ID (8'h83)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .PORT_ID  (PORT_ID),
        .OUT_PORT (OUT_PORT),
        .IO_STRB  (IO_STRB),
        .TX       (TX),
        .STATUS   (STATUS),
        .TX_DONE  (TX_DONE)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of bytes plus position within the current frame.
    logic [7:0] m_q[$];
    logic       m_active = 1'b0;
    int         m_pos = 0;
    logic [7:0] m_byte = 8'h00;
    logic       m_ovr = 1'b0;
    logic       m_done = 1'b0;

    always @(posedge CLK or negedge RST_N) begin
        int   pre;
        logic popped;
        if (!RST_N) begin
            m_q.delete();
            m_active = 1'b0;
            m_pos    = 0;
            m_ovr    = 1'b0;
            m_done   = 1'b0;
        end else begin
            pre    = m_q.size();
            popped = 1'b0;
            m_done = 1'b0;
            if (m_active) begin
                if (m_pos == 10*C - 1) begin
                    m_active = 1'b0;
                    m_done   = (pre == 0);
                end else begin
                    m_pos++;
                end
            end else if (pre > 0) begin
                m_byte   = m_q.pop_front();
                m_active = 1'b1;
                m_pos    = 0;
                popped   = 1'b1;
            end
            if (IO_STRB && PORT_ID == 8'h82) begin
                if (pre < 8 || popped) m_q.push_back(OUT_PORT);
                else m_ovr = 1'b1;
            end
            if (IO_STRB && PORT_ID == 8'h83) m_ovr = 1'b0;
        end
    end

    function automatic logic exp_tx();
        if (!m_active) return 1'b1;
        if (m_pos < C) return 1'b0;
        if (m_pos >= 9*C) return 1'b1;
        return m_byte[m_pos/C - 1];
    endfunction

    function automatic logic [7:0] exp_status();
        int n;
        n = m_q.size();
        return {n[3:0], m_ovr, m_active, (n == 8), (n == 0)};
    endfunction

    always @(negedge CLK) begin
        check("model_tx", TX, exp_tx());
        check("model_status", STATUS, exp_status());
        check("model_done", TX_DONE, m_done);
    end

    // Serial receiver: samples mid-bit, records frame start cycles.
    logic [7:0] rx_q[$];
    int         rx_start[$];
    int         cyc = 0;
    int         rx_cnt = -1;
    logic [7:0] rx_sh = 8'h00;
    int         done_cnt = 0;
    int         low_cnt = 0;

    always @(negedge CLK) begin
        cyc++;
        if (TX_DONE) done_cnt++;
        if (!TX) low_cnt++;
        if (!RST_N) begin
            rx_cnt = -1;
        end else if (rx_cnt < 0) begin
            if (TX === 1'b0) begin
                rx_cnt = 0;
                rx_start.push_back(cyc);
            end
        end else begin
            rx_cnt++;
            if (rx_cnt % C == 2 && rx_cnt / C >= 1 && rx_cnt / C <= 8)
                rx_sh[rx_cnt/C - 1] = TX;
            if (rx_cnt == 9*C + 2) begin
                check("rx_stop_bit", TX, 1'b1);
                rx_q.push_back(rx_sh);
                rx_cnt = -1;
            end
        end
    end

    logic [7:0] exp_bytes [10] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                                   8'h06, 8'h07, 8'h08, 8'h09, 8'h5A};

    // Caller sits at a negedge; the write is sampled at the following posedge.
    task automatic wr(input logic [7:0] id, input logic [7:0] d);
        PORT_ID  = id;
        OUT_PORT = d;
        IO_STRB  = 1'b1;
        @(negedge CLK);
        IO_STRB  = 1'b0;
        PORT_ID  = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish before 100000 ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         n;
        int         d0;
        int         l0;
        int         base_rx;
        int         base_st;
        logic [9:0] fr;

        // Reset
        idle(3);
        check("rst_tx", TX, 1'b1);
        check("rst_status", STATUS, 8'h01);
        check("rst_done", TX_DONE, 1'b0);
        #2 RST_N = 1'b1;
        @(negedge CLK);
        idle(5);
        check("post_rst_tx_low_cycles", low_cnt, 0);

        // Decode rejection
        wr(8'h40, 8'h11);
        check("rej_port_status", STATUS, 8'h01);
        PORT_ID  = 8'h82;
        OUT_PORT = 8'h22;
        IO_STRB  = 1'b0;
        @(negedge CLK);
        PORT_ID  = 8'h00;
        check("rej_strb_status", STATUS, 8'h01);
        idle(10);
        check("rej_tx_low_cycles", low_cnt, 0);
        check("rej_rx_count", rx_q.size(), 0);

        // Single byte A5: start, LSB-first data 1,0,1,0,0,1,0,1, stop
        fr = 10'b1101001010;
        d0 = done_cnt;
        wr(8'h82, 8'hA5);
        check("single_after_push_status", STATUS, 8'h10);
        check("single_after_push_tx", TX, 1'b1);
        @(negedge CLK);
        check("single_popped_status", STATUS, 8'h05);
        for (int k = 0; k < 10*C; k++) begin
            check("single_frame_bit", TX, fr[k/C]);
            @(negedge CLK);
        end
        check("single_done_high", TX_DONE, 1'b1);
        check("single_end_status", STATUS, 8'h01);
        @(negedge CLK);
        check("single_done_low", TX_DONE, 1'b0);
        check("single_done_pulses", done_cnt - d0, 1);

        // Fill, overflow, overrun clear, push onto full FIFO during pop
        base_rx = rx_q.size();
        base_st = rx_start.size();
        d0 = done_cnt;
        for (int i = 1; i <= 9; i++) wr(8'h82, 8'(i));
        check("fill_status", STATUS, 8'h86);
        wr(8'h82, 8'hEE);
        check("overflow_status", STATUS, 8'h8E);
        wr(8'h83, 8'h5C);
        check("overrun_clear_status", STATUS, 8'h86);
        n = 0;
        while (STATUS[2] && n < 100) begin
            @(negedge CLK);
            n++;
        end
        check("idle_slot_reached", (n < 100), 1'b1);
        check("idle_slot_status", STATUS, 8'h82);
        wr(8'h82, 8'h5A);
        check("full_pop_push_status", STATUS, 8'h86);
        n = 0;
        while (rx_q.size() < base_rx + 10 && n < 800) begin
            @(negedge CLK);
            n++;
        end
        check("drain_in_time", (n < 800), 1'b1);
        idle(4);
        check("drain_rx_count", rx_q.size() - base_rx, 10);
        if (rx_q.size() >= base_rx + 10) begin
            for (int i = 0; i < 10; i++)
                check("drain_rx_byte", rx_q[base_rx + i], exp_bytes[i]);
        end
        if (rx_start.size() >= base_st + 10) begin
            for (int i = 0; i < 9; i++)
                check("frame_spacing", rx_start[base_st + i + 1] - rx_start[base_st + i], 41);
        end
        check("drain_done_pulses", done_cnt - d0, 1);
        check("drain_end_status", STATUS, 8'h01);

        // Reset in the middle of a start bit with a byte still queued
        wr(8'h82, 8'h33);
        wr(8'h82, 8'h44);
        idle(1);
        check("pre_reset_tx", TX, 1'b0);
        #2 RST_N = 1'b0;
        #1;
        check("mid_rst_tx", TX, 1'b1);
        check("mid_rst_status", STATUS, 8'h01);
        check("mid_rst_done", TX_DONE, 1'b0);
        idle(3);
        #2 RST_N = 1'b1;
        @(negedge CLK);
        l0 = low_cnt;
        idle(60);
        check("post_mid_rst_tx_low_cycles", low_cnt - l0, 0);
        check("post_mid_rst_status", STATUS, 8'h01);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
